// File: rtl/dataflow_rx.sv
// dataflow_rx: 16x oversampled receiver for one parity-protected serial frame.
//
//  state  | meaning
//  -------+--------------------------------------------------------------
//  IDLE   | line idle, waiting for Rx = 0 (start edge)
//  START  | counting to mid start bit; Rx = 1 there is a glitch -> IDLE
//  DATA   | sampling n payload bits, LSB first, one per 16 cycles
//  PARITY | sampling the parity bit (only when parity_check was set)
//  STOP   | sampling the stop bit; frame results are published here
//
// The oversample counter is cleared at the start edge and free-runs while
// a frame is in progress. Every sample point of the frame therefore falls
// on the edge where the counter reads 7: T0+8, then every 16 cycles.
module dataflow_rx #(
  parameter int n = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         Rx,
  input  logic         parity_check,
  input  logic         parity_type_even_odd,
  output logic [n-1:0] out_buffer,
  output logic         correct,
  output logic         Rx_idle
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } state_t;

  localparam logic [n-1:0] FIRST_BIT = {{(n-1){1'b0}}, 1'b1};

  state_t       state;
  state_t       state_nxt;
  logic [3:0]   os_cnt;
  logic [n-1:0] shift_reg;
  logic [n-1:0] bit_mark;
  logic         par_en;
  logic         par_odd;
  logic         parity_ok;
  logic         mid_bit;

  assign mid_bit = (os_cnt == 4'd7);
  assign Rx_idle = (state == IDLE);

  // State register with synchronous active-high reset.
  always_ff @(posedge clk) begin
    if (rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state decode; every transition after the start edge waits for mid-bit.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (!Rx) state_nxt = START;
      end
      START: begin
        if (mid_bit) state_nxt = Rx ? IDLE : DATA;
      end
      DATA: begin
        if (mid_bit && bit_mark[n-1]) state_nxt = par_en ? PARITY : STOP;
      end
      PARITY: begin
        if (mid_bit) state_nxt = STOP;
      end
      STOP: begin
        if (mid_bit) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Oversample counter, payload shifter, frame configuration and results.
  always_ff @(posedge clk) begin
    if (rst_n) begin
      os_cnt     <= 4'd0;
      shift_reg  <= '0;
      bit_mark   <= '0;
      par_en     <= 1'b0;
      par_odd    <= 1'b0;
      parity_ok  <= 1'b0;
      out_buffer <= '0;
      correct    <= 1'b0;
    end else begin
      if (state == IDLE) begin
        os_cnt <= 4'd0;
      end else begin
        os_cnt <= os_cnt + 4'd1;
      end

      case (state)
        IDLE: begin
          if (!Rx) begin
            // Frame format is latched at the start edge and held to the stop bit.
            par_en    <= parity_check;
            par_odd   <= parity_type_even_odd;
            bit_mark  <= FIRST_BIT;
            parity_ok <= 1'b0;
          end
        end
        DATA: begin
          if (mid_bit) begin
            // Shift in from the top so the first (LSB) bit lands at index 0
            // after n samples; bit_mark tracks which bit is being taken.
            shift_reg <= {Rx, shift_reg[n-1:1]};
            bit_mark  <= bit_mark << 1;
          end
        end
        PARITY: begin
          if (mid_bit) parity_ok <= (Rx == ((^shift_reg) ^ par_odd));
        end
        STOP: begin
          if (mid_bit) begin
            // Payload is published even when the frame is bad.
            out_buffer <= shift_reg;
            correct    <= Rx & (parity_ok | ~par_en);
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dataflow_rx.sv
// tb_dataflow_rx: directed frames into dataflow_rx with a scoreboard of expected results.
module tb_dataflow_rx;

  localparam int N = 8;

  logic         clk;
  logic         rst_n;
  logic         Rx;
  logic         parity_check;
  logic         parity_type_even_odd;
  logic [N-1:0] out_buffer;
  logic         correct;
  logic         Rx_idle;

  typedef struct {
    logic [N-1:0] data;
    logic         corr;
  } exp_t;

  exp_t sb[$];
  int   vectors = 0;
  int   errors  = 0;
  int   cyc     = 0;
  logic [N-1:0] last_data = '0;
  logic         last_corr = 1'b0;

  dataflow_rx #(.n(N)) dut (
    .clk                  (clk),
    .rst_n                (rst_n),
    .Rx                   (Rx),
    .parity_check         (parity_check),
    .parity_type_even_odd (parity_type_even_odd),
    .out_buffer           (out_buffer),
    .correct              (correct),
    .Rx_idle              (Rx_idle)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Posedge count; at a negedge it equals the index of the last rising edge.
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_done(input int t0);
    exp_t e;
    int   lat;
    lat = parity_check ? 168 : 152;
    chk("latency", 32'(cyc - t0), 32'(lat));
    if (sb.size() == 0) begin
      chk("sb_empty", 32'd0, 32'd1);
    end else begin
      e = sb.pop_front();
      chk("out_buffer", 32'(out_buffer), 32'(e.data));
      chk("correct", 32'(correct), 32'(e.corr));
      last_data = e.data;
      last_corr = e.corr;
    end
  endtask

  // Call at a negedge; the following rising edge is T0.
  task automatic send_frame(input logic [N-1:0] data, input logic flip_par,
                            input logic bad_stop);
    logic fr[0:N+2];
    int   nb;
    int   t0;
    bit   seen;
    logic p;
    exp_t e;
    fr[0] = 1'b0;
    for (int k = 0; k < N; k++) fr[k+1] = data[k];
    nb = N + 1;
    if (parity_check) begin
      p = 1'b0;
      for (int k = 0; k < N; k++) p = p ^ data[k];
      fr[nb] = p ^ parity_type_even_odd ^ flip_par;
      nb++;
    end
    fr[nb] = ~bad_stop;
    nb++;
    e.data = data;
    e.corr = !bad_stop && !(parity_check && flip_par);
    sb.push_back(e);
    t0   = cyc + 1;
    seen = 0;
    for (int b = 0; b < nb; b++) begin
      Rx = fr[b];
      repeat (16) begin
        @(negedge clk);
        if (!seen && Rx_idle) begin
          seen = 1;
          check_done(t0);
        end
      end
    end
    Rx = 1'b1;
    if (!seen) begin
      chk("frame_timeout", 32'd0, 32'd1);
      void'(sb.pop_front());
    end
  endtask

  initial begin
    int t0;
    Rx                   = 1'b1;
    rst_n                = 1'b1;
    parity_check         = 1'b1;
    parity_type_even_odd = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    chk("rst_out_buffer", 32'(out_buffer), 32'h0);
    chk("rst_correct", 32'(correct), 32'd0);
    chk("rst_idle", 32'(Rx_idle), 32'd1);
    repeat (4) @(negedge clk);

    // Even parity, then odd parity good and flipped, back to back.
    send_frame(8'h55, 1'b0, 1'b0);
    parity_type_even_odd = 1'b1;
    send_frame(8'hA3, 1'b0, 1'b0);
    send_frame(8'hA3, 1'b1, 1'b0);

    // No parity bit: 10-bit frame.
    parity_check = 1'b0;
    send_frame(8'h0F, 1'b0, 1'b0);
    repeat (10) @(negedge clk);

    // Start glitch: 3 low cycles.
    Rx = 1'b0;
    t0 = cyc + 1;
    @(negedge clk);
    chk("glitch_busy", 32'(Rx_idle), 32'd0);
    repeat (2) @(negedge clk);
    Rx = 1'b1;
    for (int i = 0; i < 20 && !Rx_idle; i++) @(negedge clk);
    chk("glitch_idle_cyc", 32'(cyc - t0), 32'd8);
    chk("glitch_out_buffer", 32'(out_buffer), 32'(last_data));
    chk("glitch_correct", 32'(correct), 32'(last_corr));
    repeat (10) @(negedge clk);

    // Bad stop bit, then a clean frame after the line settles.
    parity_check         = 1'b1;
    parity_type_even_odd = 1'b0;
    send_frame(8'h3C, 1'b0, 1'b1);
    repeat (24) @(negedge clk);
    send_frame(8'h81, 1'b0, 1'b0);
    repeat (5) @(negedge clk);

    // Reset during DATA of a 0xFF frame.
    Rx = 1'b0;
    repeat (16) @(negedge clk);
    Rx = 1'b1;
    repeat (40) @(negedge clk);
    chk("busy_before_reset", 32'(Rx_idle), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    rst_n = 1'b0;
    chk("midrst_out_buffer", 32'(out_buffer), 32'h0);
    chk("midrst_correct", 32'(correct), 32'd0);
    chk("midrst_idle", 32'(Rx_idle), 32'd1);
    repeat (40) @(negedge clk);
    send_frame(8'h12, 1'b0, 1'b0);
    repeat (5) @(negedge clk);

    chk("sb_drained", 32'(sb.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule

// File: doc/dataflow_rx.md
# dataflow_rx

Serial receiver that recovers one parity-protected frame from the single-wire line driven by the companion `Dataflow_Tx` transmitter. The line carries one bit per 16 `clk` cycles, so the receiver runs at 16x oversampling and samples each bit at its centre. It delivers the n-bit payload in `out_buffer` together with a `correct` flag, and reports idleness on `Rx_idle` for upstream flow control.

## Interface
- `n`, default 8: payload width in bits.

- `clk`  in  1  receiver clock; the bit period is exactly 16 `clk` cycles.
- `rst_n`  in  1  synchronous reset, active-high (1 = reset at the next `clk` rising edge).
- `Rx`  in  1  serial line; idles high; synchronous to `clk`; no internal synchronizer.
- `parity_check`  in  1  1 = frame contains a parity bit; 0 = no parity bit.
- `parity_type_even_odd`  in  1  0 = even parity; 1 = odd parity.
- `out_buffer`  out  n  last received payload.
- `correct`  out  1  1 = last frame had good parity (if enabled) and a good stop bit.
- `Rx_idle`  out  1  1 = receiver waiting for a start bit.

## Operation
- Frame, in line order:
  - start bit (0);
  - n data bits, LSB first;
  - parity bit, present only if `parity_check` = 1;
  - stop bit (1).
- Even parity bit = XOR of the data bits. Odd parity bit = its inverse.
- `parity_check` and `parity_type_even_odd` are sampled when the start bit is detected and held for the whole frame.
- State machine: IDLE, START, DATA, PARITY, STOP.
  - IDLE: `Rx_idle` = 1. `Rx` = 0 on an edge moves to START and clears the 4-bit oversample counter.
  - START: counts 8 cycles to mid-bit and samples `Rx` there.
    - `Rx` = 1 at mid-bit is treated as a glitch: return to IDLE, outputs unchanged.
    - `Rx` = 0 at mid-bit: go to DATA.
  - DATA: samples every 16 cycles. Each sample shifts into the payload register at bit index k (LSB first). After n samples, go to PARITY if enabled, else STOP.
  - PARITY: one sample 16 cycles after the last data sample. Store parity_ok = (sample == expected parity).
  - STOP: one sample 16 cycles after the previous sample. stop_ok = (sample == 1).
- Frame completion, on the same edge as the STOP sample:
  - `out_buffer` ← payload, always updated, even on error;
  - `correct` ← stop_ok AND (parity_ok OR `parity_check` = 0);
  - state → IDLE.
- `out_buffer` and `correct` hold their values until the next completed frame. A glitch abort does not change them.
- Back-to-back frames: the receiver is in IDLE during the second half of the stop bit, so a start edge immediately after the stop bit is caught.

## Timing
- Reset values: `out_buffer` = 0, `correct` = 0, `Rx_idle` = 1, state = IDLE, counter = 0.
- Reset mid-frame abandons the frame; outputs return to reset values on that edge.
- T0 = the edge at which `Rx` = 0 is first seen in IDLE. Sample points:
  - start sample: T0+8;
  - data bit k (k = 0..n-1): T0+8+16(k+1);
  - parity sample: T0+8+16(n+1);
  - stop sample: T0+8+16(n+1+p), where p = `parity_check`.
- Outputs update on the stop-sample edge and are visible from the next cycle.
- For n = 8 with parity, outputs are valid from cycle T0+169.
- `Rx_idle` is 0 from the cycle after T0 through the stop-sample edge, and 1 after it.
- Counter width is 4 bits and wraps at 16 (0..15); no other arithmetic.

## Test plan
- Default n = 8, even parity, `parity_check` = 1; `Dataflow_Tx` sends 0x55 on a clock divided by 16 from `clk` -> `out_buffer` = 0x55, `correct` = 1, `Rx_idle` returns to 1 about 169 cycles after the start edge.
- Odd parity (`parity_type_even_odd` = 1); send 0xA3 with the correct odd parity bit -> `out_buffer` = 0xA3, `correct` = 1. Repeat with the parity bit flipped -> `out_buffer` = 0xA3, `correct` = 0.
- `parity_check` = 0, 10-bit frame carrying 0x0F -> `out_buffer` = 0x0F, `correct` = 1, stop sampled at T0+152.
- Stop bit forced to 0, payload 0x3C -> `out_buffer` = 0x3C, `correct` = 0; the next valid frame, 0x81, is received with `correct` = 1.
- `Rx` low for 3 cycles then high -> `Rx_idle` drops, then returns to 1 at T0+8; `out_buffer` and `correct` unchanged.
- `rst_n` = 1 during DATA of a 0xFF frame -> next cycle `out_buffer` = 0, `correct` = 0, `Rx_idle` = 1. The following complete frame, 0x12, is received correctly.
